video_timing_decoder: RTL

//  Receive-side counterpart of the pixel timing generator: takes a 24-bit parallel video stream
//  (pData/pHSync/pVSync/pVDE) and recovers pixel_x/pixel_y plus de-swapped RGB colour.

---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/video_timing_decoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Timing constants, FSM encoding and measurement types shared by the video timing
// generator and decoder.
package video_timing_pkg;

    localparam int H_ACTIVE_720P   = 1280;
    localparam int V_ACTIVE_720P   = 720;
    localparam int H_FRAME_720P    = 1650;
    localparam int V_FRAME_720P    = 750;
    localparam int LOCK_FRAMES_DEF = 2;

    localparam int MEAS_W  = 16;
    localparam int MATCH_W = 8;

    typedef logic [MEAS_W-1:0]  meas_t;
    typedef logic [MATCH_W-1:0] match_t;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    // Measurement counters stick at all-ones so an absent sync never aliases to a valid period.
    function automatic meas_t sat_inc(input meas_t v);
        return (v == '1) ? v : v + meas_t'(1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync/enable bit and reports single-cycle rise/fall pulses relative to the
// previous registered value.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            level_q <= d_i;
            prev_q  <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/video_timing_decoder.sv
// Receive-side video timing decoder: recovers pixel coordinates and RGB colour from a parallel
// sync/DE stream and declares lock once line and frame timing match the expected mode.
module video_timing_decoder
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE_VIDEO = H_ACTIVE_720P,
    parameter int V_ACTIVE_VIDEO = V_ACTIVE_720P,
    parameter int H_FRAME        = H_FRAME_720P,
    parameter int V_FRAME        = V_FRAME_720P,
    parameter int LOCK_FRAMES    = LOCK_FRAMES_DEF
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [23:0] video_in_pData,
    input  logic        video_in_pHSync,
    input  logic        video_in_pVSync,
    input  logic        video_in_pVDE,
    output logic [31:0] pixel_x,
    output logic [31:0] pixel_y,
    output logic [23:0] pixel_color,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_error
);

    localparam meas_t  H_ACT_M = meas_t'(H_ACTIVE_VIDEO);
    localparam meas_t  H_FRM_M = meas_t'(H_FRAME);
    localparam meas_t  V_ACT_M = meas_t'(V_ACTIVE_VIDEO);
    localparam meas_t  V_FRM_M = meas_t'(V_FRAME);
    localparam match_t LOCK_M  = match_t'(LOCK_FRAMES);

    logic hs_lvl, hs_rise, hs_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic vde_q, vde_rise, vde_fall;
    logic unused_sync;

    sync_edge_detect u_hs (.clk_i(pixel_clk), .rst_i(rst), .d_i(video_in_pHSync),
                           .level_o(hs_lvl), .rise_o(hs_rise), .fall_o(hs_fall));
    sync_edge_detect u_vs (.clk_i(pixel_clk), .rst_i(rst), .d_i(video_in_pVSync),
                           .level_o(vs_lvl), .rise_o(vs_rise), .fall_o(vs_fall));
    sync_edge_detect u_de (.clk_i(pixel_clk), .rst_i(rst), .d_i(video_in_pVDE),
                           .level_o(vde_q), .rise_o(vde_rise), .fall_o(vde_fall));

    assign unused_sync = ^{hs_lvl, hs_fall, vs_lvl, vs_fall};

    logic [23:0] data_q;
    lock_state_e state_q, state_d;
    match_t      match_q, match_d;
    meas_t       h_cnt_q, h_cnt_d;
    meas_t       a_cnt_q, a_cnt_d;
    meas_t       v_cnt_q, v_cnt_d;
    meas_t       va_cnt_q, va_cnt_d;
    logic        h_seen_q, h_seen_d;
    logic        line_bad_q, line_bad_d;
    logic        pend_q, pend_d;
    logic [31:0] x_q, x_d, y_q, y_d;
    logic [23:0] color_q, color_d;
    logic        valid_q, valid_d, fs_q, fs_d, locked_q, locked_d, terr_q, terr_d;

    logic line_bad_now;
    logic frame_ok;

    // A line is only judged once a full HSync period has been observed since reset.
    assign line_bad_now = (hs_rise && h_seen_q && (h_cnt_q != H_FRM_M))
                        | (vde_fall && (a_cnt_q != H_ACT_M));
    assign frame_ok     = !line_bad_q && !line_bad_now
                        && (v_cnt_q == V_FRM_M) && (va_cnt_q == V_ACT_M);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        h_cnt_d    = hs_rise ? meas_t'(1) : sat_inc(h_cnt_q);
        a_cnt_d    = a_cnt_q;
        v_cnt_d    = v_cnt_q;
        va_cnt_d   = va_cnt_q;
        h_seen_d   = h_seen_q | hs_rise;
        line_bad_d = line_bad_q;
        pend_d     = pend_q;
        x_d        = x_q;
        y_d        = y_q;
        fs_d       = 1'b0;

        if (vde_rise)   a_cnt_d = meas_t'(1);
        else if (vde_q) a_cnt_d = sat_inc(a_cnt_q);

        // Each frame window runs from one VSync rise up to (not including) the next.
        if (vs_rise) begin
            v_cnt_d    = hs_rise  ? meas_t'(1) : meas_t'(0);
            va_cnt_d   = vde_rise ? meas_t'(1) : meas_t'(0);
            line_bad_d = 1'b0;
        end else begin
            if (hs_rise)      v_cnt_d    = sat_inc(v_cnt_q);
            if (vde_rise)     va_cnt_d   = sat_inc(va_cnt_q);
            if (line_bad_now) line_bad_d = 1'b1;
        end

        if (vde_rise) begin
            x_d    = 32'd0;
            pend_d = 1'b0;
            if (vs_rise || pend_q) begin
                y_d  = 32'd0;
                fs_d = 1'b1;
            end
        end else begin
            if (vde_q)    x_d    = x_q + 32'd1;
            if (vde_fall) y_d    = y_q + 32'd1;
            if (vs_rise)  pend_d = 1'b1;
        end

        color_d = {data_q[23:16], data_q[7:0], data_q[15:8]};
        valid_d = vde_q & locked_q;
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        terr_d  = 1'b0;
        unique case (state_q)
            ST_SEARCH: begin
                if (vs_rise) begin
                    state_d = ST_MEASURE;
                    match_d = '0;
                end
            end
            ST_MEASURE: begin
                if (vs_rise) begin
                    if (!frame_ok) begin
                        match_d = '0;
                    end else if (match_t'(match_q + 8'd1) >= LOCK_M) begin
                        match_d = LOCK_M;
                        state_d = ST_LOCKED;
                    end else begin
                        match_d = match_t'(match_q + 8'd1);
                    end
                end
            end
            ST_LOCKED: begin
                if (line_bad_now || (vs_rise && !frame_ok)) begin
                    terr_d  = 1'b1;
                    match_d = '0;
                    state_d = ST_MEASURE;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                match_d = '0;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            state_q    <= ST_SEARCH;
            match_q    <= '0;
            h_cnt_q    <= '0;
            a_cnt_q    <= '0;
            v_cnt_q    <= '0;
            va_cnt_q   <= '0;
            h_seen_q   <= 1'b0;
            line_bad_q <= 1'b0;
            pend_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            color_q    <= '0;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            locked_q   <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            data_q     <= video_in_pData;
            state_q    <= state_d;
            match_q    <= match_d;
            h_cnt_q    <= h_cnt_d;
            a_cnt_q    <= a_cnt_d;
            v_cnt_q    <= v_cnt_d;
            va_cnt_q   <= va_cnt_d;
            h_seen_q   <= h_seen_d;
            line_bad_q <= line_bad_d;
            pend_q     <= pend_d;
            x_q        <= x_d;
            y_q        <= y_d;
            color_q    <= color_d;
            valid_q    <= valid_d;
            fs_q       <= fs_d;
            locked_q   <= locked_d;
            terr_q     <= terr_d;
        end
    end

    assign pixel_x      = x_q;
    assign pixel_y      = y_q;
    assign pixel_color  = color_q;
    assign pixel_valid  = valid_q;
    assign frame_start  = fs_q;
    assign locked       = locked_q;
    assign timing_error = terr_q;

endmodule
